multiplier_request_initiator: RTL and testbench

//   Host-side initiator for the p-bit multiplier (multiplier_two_bit). Accepts one

---
 rtl/pbit_mult_pkg.sv | 18 +
 rtl/pbit_result_checker.sv | 23 ++
 rtl/multiplier_request_initiator.sv | 163 ++++++++++++++++
 tb/tb_multiplier_request_initiator.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pbit_mult_pkg.sv
// Shared definitions for the p-bit multiplier host initiator: FSM states and response status codes.
package pbit_mult_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_TIMEOUT  = 2'b01,
        ST_MISMATCH = 2'b10
    } status_e;

endpackage

// File: rtl/pbit_result_checker.sv
// Combinational sanity check of a multiplier result; used by the initiator only when
// PBIT_RESULT_VERIFY_EN is defined.
module pbit_result_checker #(
    parameter int P2 = 3,
    parameter int P3 = 1
) (
    input  logic        mode_i,
    input  logic [P3:0] a_i,
    input  logic [P3:0] b_i,
    input  logic [P2:0] op_i,
    input  logic [P2:0] res_i,
    output logic        ok_o
);

    logic [P2:0] prod_ab;
    logic [P2:0] prod_f;

    // Factor mode: the two result halves are the factors and must multiply back to op.
    assign prod_ab = (P2+1)'(a_i) * (P2+1)'(b_i);
    assign prod_f  = (P2+1)'(res_i[P2:P3+1]) * (P2+1)'(res_i[P3:0]);
    assign ok_o    = mode_i ? (prod_f == op_i) : (res_i == prod_ab);

endmodule

// File: rtl/multiplier_request_initiator.sv
// Host-side initiator for the p-bit multiplier: one request in flight, timeout with bounded
// retries. Define PBIT_RESULT_VERIFY_EN to check results and retry on a bad answer.
module multiplier_request_initiator
    import pbit_mult_pkg::*;
#(
    parameter int P              = 7,
    parameter int P2             = ((P+1)/2)-1,
    parameter int P3             = ((P+1)/4)-1,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRIES    = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_mode,
    input  logic [P3:0] req_a,
    input  logic [P3:0] req_b,
    input  logic [P2:0] req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [P2:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic        MODE,
    output logic        valid_in,
    output logic [P3:0] in1,
    output logic [P3:0] in2,
    output logic [P2:0] op,
    input  logic [P2:0] res,
    input  logic        valid_res
);

    localparam int            RW      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int            CW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] MAXR    = RW'(MAX_RETRIES);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    status_e       status_q, status_d;
    logic          mode_q, mode_d;
    logic [P3:0]   a_q, a_d, b_q, b_d;
    logic [P2:0]   op_q, op_d;
    logic [P2:0]   data_q, data_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [CW-1:0] tcnt_q, tcnt_d;

`ifdef PBIT_RESULT_VERIFY_EN
    logic chk_ok;

    pbit_result_checker #(.P2(P2), .P3(P3)) u_checker (
        .mode_i (mode_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .op_i   (op_q),
        .res_i  (data_q),
        .ok_o   (chk_ok)
    );
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            status_q <= ST_OK;
            mode_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            data_q   <= '0;
            retry_q  <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            data_q   <= data_d;
            retry_q  <= retry_d;
            tcnt_q   <= tcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        data_d   = data_q;
        retry_d  = retry_q;
        tcnt_d   = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    mode_d  = req_mode;
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = req_op;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result landing on the timeout cycle is still taken.
                if (valid_res) begin
                    data_d  = res;
                    state_d = S_CHECK;
                end else if (tcnt_q == TO_LAST) begin
                    if (retry_q < MAXR) begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_ISSUE;
                    end else begin
                        status_d = ST_TIMEOUT;
                        data_d   = '0;
                        state_d  = S_RESP;
                    end
                end else begin
                    tcnt_d = tcnt_q + CW'(1);
                end
            end
            S_CHECK: begin
`ifdef PBIT_RESULT_VERIFY_EN
                if (chk_ok) begin
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end else if (retry_q < MAXR) begin
                    retry_d = retry_q + RW'(1);
                    state_d = S_ISSUE;
                end else begin
                    status_d = ST_MISMATCH;
                    state_d  = S_RESP;
                end
`else
                status_d = ST_OK;
                state_d  = S_RESP;
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    retry_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign valid_in   = (state_q == S_ISSUE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_data   = data_q;
    assign rsp_status = status_q;
    assign MODE       = mode_q;
    assign in1        = a_q;
    assign in2        = b_q;
    assign op         = op_q;

endmodule

// File: tb/tb_multiplier_request_initiator.sv
// Directed plus randomized bench for multiplier_request_initiator with a scripted multiplier stub.
module tb_multiplier_request_initiator;

    localparam int P = 7, P2 = 3, P3 = 1, T = 8, MR = 2;
`ifdef PBIT_RESULT_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid, req_ready, req_mode;
    logic [P3:0] req_a, req_b, in1, in2;
    logic [P2:0] req_op, rsp_data, op, res;
    logic        rsp_valid, rsp_ready, MODE, valid_in, valid_res;
    logic [1:0]  rsp_status;

    multiplier_request_initiator #(.P(P), .TIMEOUT_CYCLES(T), .MAX_RETRIES(MR)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_status(rsp_status),
        .MODE(MODE), .valid_in(valid_in), .in1(in1), .in2(in2), .op(op),
        .res(res), .valid_res(valid_res)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Stub: per valid_in pulse pop one scripted reply (value < 0 means stay silent).
    int rep_val[$], rep_dly[$];
    int pend = 0, pval = 0;
    initial begin
        valid_res = 1'b0;
        res = '0;
        forever begin
            @(posedge CLK); #1;
            valid_res = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    valid_res = 1'b1;
                    res = 4'(pval);
                end
            end
            if (valid_in && rep_val.size() > 0) begin
                int v, d;
                v = rep_val.pop_front();
                d = rep_dly.pop_front();
                if (v >= 0) begin
                    pval = v;
                    pend = d;
                end
            end
        end
    end

    int pulses[$];
    initial forever begin
        @(posedge CLK); #1;
        if (valid_in) pulses.push_back(cyc);
    end

    int total = 0, passed = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference model: walk the attempts, timing each as issue + wait (+ check).
    int tv[$], td[$];
    int m_st, m_dat, m_lat;
    int m_pc[$];
    task automatic model(input bit md, input int a, input int b, input int opv);
        int t = 0;
        m_st = 0; m_dat = 0;
        m_pc.delete();
        for (int k = 0; k <= MR; k++) begin
            m_pc.push_back(t + 1);
            if (k >= tv.size() || tv[k] < 0) begin
                t += 1 + T;
                if (k == MR) begin m_st = 1; m_dat = 0; end
            end else begin
                int r;
                bit ok;
                r = tv[k];
                t += 1 + td[k] + 1;
                if (md) ok = ((r >> (P3+1)) * (r % (1 << (P3+1)))) == opv;
                else    ok = (r == a * b);
                ok = ok || !VERIFY;
                if (ok || k == MR) begin
                    m_st = ok ? 0 : 2;
                    m_dat = r;
                    break;
                end
            end
        end
        m_lat = t + 1;
    endtask

    task automatic run_txn(input string tag, input bit md, input int a, input int b,
                           input int opv, input int hold);
        int c0;
        bit seen;
        model(md, a, b, opv);
        rep_val = tv; rep_dly = td;
        pulses.delete();
        chk({tag, ".req_ready"}, 32'(req_ready), 1);
        req_mode = md; req_a = 2'(a); req_b = 2'(b); req_op = 4'(opv);
        req_valid = 1'b1;
        c0 = cyc;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        chk({tag, ".valid_in"}, 32'(valid_in), 1);
        chk({tag, ".MODE"}, 32'(MODE), 32'(md));
        chk({tag, ".in1"}, 32'(in1), 32'(a));
        chk({tag, ".in2"}, 32'(in2), 32'(b));
        chk({tag, ".op"}, 32'(op), 32'(opv));
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (rsp_valid) seen = 1'b1;
            else begin @(posedge CLK); #1; end
        end
        chk({tag, ".rsp_seen"}, 32'(seen), 1);
        if (seen) begin
            chk({tag, ".latency"}, 32'(cyc - c0), 32'(m_lat));
            chk({tag, ".data"}, 32'(rsp_data), 32'(m_dat));
            chk({tag, ".status"}, 32'(rsp_status), 32'(m_st));
            chk({tag, ".pulses"}, 32'(pulses.size()), 32'(m_pc.size()));
            if (pulses.size() == m_pc.size())
                foreach (m_pc[i]) chk({tag, ".pulse_cyc"}, 32'(pulses[i] - c0), 32'(m_pc[i]));
            for (int i = 0; i < hold; i++) begin
                req_valid = 1'b1;
                @(posedge CLK); #1;
                chk({tag, ".hold_valid"}, 32'(rsp_valid), 1);
                chk({tag, ".hold_data"}, 32'(rsp_data), 32'(m_dat));
                chk({tag, ".hold_status"}, 32'(rsp_status), 32'(m_st));
                chk({tag, ".hold_req_ready"}, 32'(req_ready), 0);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            @(posedge CLK); #1;
            rsp_ready = 1'b0;
            chk({tag, ".rsp_drop"}, 32'(rsp_valid), 0);
            chk({tag, ".ready_back"}, 32'(req_ready), 1);
        end
    endtask

    initial begin
        RST = 1'b1;
        req_valid = 1'b0; req_mode = 1'b0; req_a = '0; req_b = '0; req_op = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("rst.req_ready", 32'(req_ready), 1);
        chk("rst.rsp_valid", 32'(rsp_valid), 0);
        chk("rst.valid_in", 32'(valid_in), 0);
        chk("rst.outs", {MODE, in1, in2, op}, 0);
        chk("rst.rsp_data", 32'(rsp_data), 0);
        chk("rst.rsp_status", 32'(rsp_status), 0);

        tv = {6};          td = {1};          run_txn("mul3x2", 1'b0, 3, 2, 0, 0);
        tv = {-1, -1, -1}; td = {0, 0, 0};    run_txn("timeout", 1'b0, 1, 1, 0, 0);
        tv = {10, 14};     td = {2, 2};       run_txn("factor6", 1'b1, 0, 0, 6, 0);
        tv = {8, 8, 8};    td = {2, 2, 2};    run_txn("bad3x3", 1'b0, 3, 3, 0, 0);
        tv = {2};          td = {3};          run_txn("bp", 1'b0, 1, 2, 0, 5);
        tv = {6};          td = {T};          run_txn("simul", 1'b0, 3, 2, 0, 0);

        // Reset while waiting; the stub's reply then lands in IDLE and must be ignored.
        tv = {6}; td = {6};
        rep_val = tv; rep_dly = td;
        pulses.delete();
        req_mode = 1'b0; req_a = 2'd3; req_b = 2'd2; req_valid = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("rstwait.req_ready", 32'(req_ready), 1);
        chk("rstwait.rsp_valid", 32'(rsp_valid), 0);
        chk("rstwait.valid_in", 32'(valid_in), 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            chk("rstwait.late_rsp", 32'(rsp_valid), 0);
            chk("rstwait.late_ready", 32'(req_ready), 1);
        end
        chk("rstwait.pulses", 32'(pulses.size()), 1);
        tv = {4}; td = {1}; run_txn("after_rst", 1'b0, 2, 2, 0, 0);

        for (int n = 0; n < 25; n++) begin
            bit md;
            int a, b, opv, f1, f2, good;
            md = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 3); b = $urandom_range(0, 3);
            f1 = $urandom_range(0, 3); f2 = $urandom_range(0, 3);
            opv  = md ? f1 * f2 : $urandom_range(0, 15);
            good = md ? (f1 << 2) | f2 : a * b;
            tv.delete(); td.delete();
            for (int k = 0; k <= MR; k++) begin
                int c;
                c = $urandom_range(0, 3);
                tv.push_back(c == 0 ? -1 : (c == 1 ? good : int'($urandom_range(0, 15))));
                td.push_back($urandom_range(1, T));
            end
            run_txn("rand", md, a, b, opv, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
